mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
- Memory-mapped console transmitter that responds to CPU store/load accesses on the data bus and serializes bytes onto a single 8N1 UART line.
- Sits beside data memory under `top`; the CPU is the bus initiator and this block is the responder.
- Gives simulated programs a byte-output path that the testbench can decode from the `tx` pin.

Parameters:
- FIFO_DEPTH, 8, number of byte entries in the TX FIFO; must be a power of 2 and at least 2.
- DIV_RESET, 16, reset value of the DIVISOR register, in clocks per bit.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sel  input  1  bus select for this peripheral, driven by the top-level address decode.
- we  input  1  write strobe; meaningful only when sel=1.
- re  input  1  read strobe; meaningful only when sel=1.
- addr  input  2  word offset: 0=TXDATA, 1=STATUS, 2=DIVISOR, 3=reserved.
- wdata  input  32  write data.
- rdata  output  32  read data, registered.
- tx  output  1  serial line; idle level is high.
- irq  output  1  level interrupt, high when the FIFO is empty and the transmitter is idle.

Behaviour:
- Reset values: tx=1, rdata=0, irq=1, FIFO empty, overflow flag=0, DIVISOR=DIV_RESET, FSM in IDLE.
- Reset asserted mid-frame aborts the frame; tx=1 from the first clock edge where rst=1.
- Write, TXDATA (sel&we, addr=0): pushes wdata[7:0] into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and the sticky overflow flag is set.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
- Write, DIVISOR (addr=2): DIVISOR <= wdata[15:0]. A value of 0 is treated as 1. The new value takes effect at the next frame start; the current frame keeps its latched divisor.
- Writes to STATUS (addr=1) and reserved (addr=3) are ignored.
- Read (sel&re): rdata is valid the cycle after re (1-cycle latency) and holds that value until the next read.
  - STATUS: bit0=full, bit1=empty, bit2=busy (FSM not IDLE), bit3=overflow, bits 31:4=0.
  - DIVISOR: {16'b0, DIVISOR}.
  - TXDATA and reserved read as 0.
  - A STATUS read clears overflow one cycle later. If overflow is set again in that same cycle, the set wins.
- Simultaneous we and re in one cycle: both are performed.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, latch the divisor, go to START on the next cycle.
  - START: tx=0 for div clocks.
  - DATA: 8 bits, LSB first, each held for div clocks; a 3-bit index counts the bits.
  - STOP: tx=1 for div clocks, then IDLE. If the FIFO is non-empty, pop immediately, so there is exactly one IDLE cycle between frames.
- Frame length is 10*div clocks plus 1 IDLE cycle. The bit counter is a down-counter loaded with div-1 that advances on reaching 0.
- FIFO: read/write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full = same index with MSB differing; empty = pointers equal.
  - Holds exactly FIFO_DEPTH bytes.
- irq = empty & (state==IDLE), registered.

Decomposition:
- Shared package/include `uart_defs`: register offsets (TXDATA=0, STATUS=1, DIVISOR=2), STATUS bit positions, FSM state encodings.
- One natural sub-module, `sync_fifo` (parameters WIDTH and DEPTH, ports push/pop/full/empty/din/dout). It is reusable by a future `mmio_uart_rx`.

Test Plan:
1. Reset, then DIVISOR=4 and TXDATA=0x55. Required `tx` sequence, 4 clocks per bit: 0 (start), 1,0,1,0,1,0,1,0, 1 (stop). busy reads 1 during the frame; irq falls after the push and returns to 1 after the stop bit.
2. Back-to-back writes 0x41, 0x42, 0x43 with DIVISOR=2. Three contiguous frames, each 20 clocks long, separated by exactly 1 idle cycle; LSB-first decode gives "ABC".
3. With DIVISOR=100, write 10 bytes while the first frame is in progress. The first byte pops immediately, the next 8 fill the FIFO (STATUS.full=1), and the 10th is dropped with overflow=1. A STATUS read returns 0x9 or 0xD; the next read shows overflow=0; 9 frames are emitted.
4. Write DIVISOR=0 then TXDATA=0xFF. Every bit lasts 1 clock and the frame is 0 then nine 1s. A DIVISOR readback returns 0.
5. Assert rst for 1 cycle mid-DATA with 3 bytes queued. tx=1 on the next cycle, STATUS reads 0x2, DIVISOR reads DIV_RESET (16), and no further frames are emitted.
6. Change DIVISOR from 4 to 8 mid-frame. The current frame completes at 4 clocks/bit and the next frame uses 8 clocks/bit.

Source files
------------

// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - register map, status bits and FSM encodings for the MMIO UART
package uart_defs;

   typedef logic [1:0] uart_state_t;
   typedef logic [1:0] reg_addr_t;

   localparam reg_addr_t ADDR_TXDATA  = 2'd0;
   localparam reg_addr_t ADDR_STATUS  = 2'd1;
   localparam reg_addr_t ADDR_DIVISOR = 2'd2;

   localparam int STATUS_FULL_BIT  = 0;
   localparam int STATUS_EMPTY_BIT = 1;
   localparam int STATUS_BUSY_BIT  = 2;
   localparam int STATUS_OVF_BIT   = 3;

   localparam uart_state_t ST_IDLE  = 2'd0;
   localparam uart_state_t ST_START = 2'd1;
   localparam uart_state_t ST_DATA  = 2'd2;
   localparam uart_state_t ST_STOP  = 2'd3;

   // A programmed divisor of zero would stall the bit counter, so it runs as 1.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - CPU data-bus port of the MMIO UART transmitter
interface mmio_uart_tx_if;
   logic        sel;
   logic        we;
   logic        re;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output sel, we, re, addr, wdata, input rdata);
   modport slave  (input sel, we, re, addr, wdata, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module mmio_uart_tx
   import uart_defs::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd16
) (
   input  logic                 clk,
   input  logic                 rst,
   mmio_uart_tx_if.slave        bus,
   output logic                 tx,
   output logic                 irq
);
   uart_state_t state_q, state_d;
   logic [15:0] div_reg_q, div_reg_d;
   logic [15:0] div_q, div_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        tx_q, tx_d;
   logic        irq_q, irq_d;
   logic        ovf_q, ovf_d;
   logic [31:0] rdata_q, rdata_d;

   logic        wr_cyc, rd_cyc;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_dout;
   logic        unused_wdata;

   assign wr_cyc       = bus.sel & bus.we;
   assign rd_cyc       = bus.sel & bus.re;
   assign fifo_push    = wr_cyc & (bus.addr == ADDR_TXDATA);
   assign unused_wdata = ^bus.wdata[31:16];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (bus.wdata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      bit_idx_d = bit_idx_q;
      fifo_pop  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shreg_d  = fifo_dout;
               div_d    = eff_div(div_reg_q);
               cnt_d    = eff_div(div_reg_q) - 16'd1;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == 16'd0) begin
               cnt_d     = div_q - 16'd1;
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_DATA: begin
            if (cnt_q == 16'd0) begin
               cnt_d   = div_q - 16'd1;
               shreg_d = {1'b0, shreg_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_STOP: begin
            if (cnt_q == 16'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The line is registered from the next state so tx and state change on the same edge.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shreg_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   always_comb begin
      div_reg_d = div_reg_q;
      if (wr_cyc && (bus.addr == ADDR_DIVISOR)) div_reg_d = bus.wdata[15:0];

      ovf_d = ovf_q;
      if (rd_cyc && (bus.addr == ADDR_STATUS)) ovf_d = 1'b0;
      if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;

      rdata_d = rdata_q;
      if (rd_cyc) begin
         rdata_d = 32'd0;
         case (bus.addr)
            ADDR_STATUS: begin
               rdata_d[STATUS_FULL_BIT]  = fifo_full;
               rdata_d[STATUS_EMPTY_BIT] = fifo_empty;
               rdata_d[STATUS_BUSY_BIT]  = (state_q != ST_IDLE);
               rdata_d[STATUS_OVF_BIT]   = ovf_q;
            end
            ADDR_DIVISOR: rdata_d = {16'd0, div_reg_q};
            default:      rdata_d = 32'd0;
         endcase
      end

      irq_d = fifo_empty & (state_q == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         div_reg_q <= DIV_RESET;
         div_q     <= eff_div(DIV_RESET);
         cnt_q     <= 16'd0;
         shreg_q   <= 8'd0;
         bit_idx_q <= 3'd0;
         tx_q      <= 1'b1;
         irq_q     <= 1'b1;
         ovf_q     <= 1'b0;
         rdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         div_reg_q <= div_reg_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         irq_q     <= irq_d;
         ovf_q     <= ovf_d;
         rdata_q   <= rdata_d;
      end
   end

   assign tx        = tx_q;
   assign irq       = irq_q;
   assign bus.rdata = rdata_q;

endmodule
